// File: rtl/stream_fifo.sv
// First-word-fall-through elastic buffer between the stream muxer and the character consumer.
// Define STREAM_FIFO_OVERFLOW_EN to add a sticky overflow flag output.
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_available,
  output logic                  in_data_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_data_available,
  input  logic                  receiver_ready
`ifdef STREAM_FIFO_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ALMOST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_en, wr_en, drop;

  assign rd_en = (count != '0) && receiver_ready;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign wr_en = in_data_available && ((count != FULL) || rd_en);
  assign drop  = in_data_available && !wr_en;

  // One slot of headroom covers the word the muxer launches after seeing ready.
  assign in_data_ready      = !reset && (count < ALMOST);
  assign out_data_available = (count != '0);
  assign out_data           = out_data_available ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

`ifdef STREAM_FIFO_OVERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo: reset, FWFT order, fill/overflow, full pass-through,
// streaming wrap and asynchronous reset.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_data_available;
  logic       in_data_ready;
  logic [7:0] out_data;
  logic       out_data_available;
  logic       receiver_ready;
`ifdef STREAM_FIFO_OVERFLOW_EN
  logic       overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_data            (in_data),
    .in_data_available  (in_data_available),
    .in_data_ready      (in_data_ready),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .receiver_ready     (receiver_ready)
`ifdef STREAM_FIFO_OVERFLOW_EN
    ,
    .overflow           (overflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0;
    in_data_available = 1'b0;
    receiver_ready = 1'b0;

    // Reset state
    step();
    chk("rst_ready", in_data_ready, 0);
    chk("rst_avail", out_data_available, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", in_data_ready, 1);
    for (int i = 0; i < 3; i++) begin
      receiver_ready = (i == 1);
      step();
      chk("idle_avail", out_data_available, 0);
      chk("idle_data", out_data, 0);
    end
    receiver_ready = 1'b0;

    // Three words, then drain in order
    in_data_available = 1'b1;
    in_data = 8'h41; step();
    chk("abc_first_data", out_data, 8'h41);
    chk("abc_first_avail", out_data_available, 1);
    in_data = 8'h42; step();
    in_data = 8'h43; step();
    in_data_available = 1'b0;
    receiver_ready = 1'b1;
    chk("abc_0", out_data, 8'h41); step();
    chk("abc_1", out_data, 8'h42); step();
    chk("abc_2", out_data, 8'h43); step();
    chk("abc_empty", out_data_available, 0);
    chk("abc_empty_data", out_data, 0);
    receiver_ready = 1'b0;

    // Fill to 15, slack write to 16, then overflow
    do_reset();
    in_data_available = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = 8'(i);
      step();
      chk("fill_ready", in_data_ready, (i + 1 < 15) ? 1 : 0);
    end
    in_data = 8'h0F; step();
    chk("full_ready", in_data_ready, 0);
    chk("full_head", out_data, 8'h00);
`ifdef STREAM_FIFO_OVERFLOW_EN
    chk("full_no_ovf", overflow, 0);
`endif
    in_data = 8'hFF; step();
    in_data_available = 1'b0;
`ifdef STREAM_FIFO_OVERFLOW_EN
    chk("ovf_set", overflow, 1);
`endif
    receiver_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain", out_data, 8'(i));
      chk("drain_avail", out_data_available, 1);
      step();
    end
    chk("drain_empty", out_data_available, 0);
    receiver_ready = 1'b0;
`ifdef STREAM_FIFO_OVERFLOW_EN
    chk("ovf_sticky", overflow, 1);
`endif

    // Simultaneous read+write at full
    do_reset();
    in_data_available = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(8'h20 + i);
      step();
    end
    in_data = 8'h99;
    receiver_ready = 1'b1;
    chk("pass_head", out_data, 8'h20);
    step();
    in_data_available = 1'b0;
    chk("pass_head2", out_data, 8'h21);
    chk("pass_still_full", in_data_ready, 0);
`ifdef STREAM_FIFO_OVERFLOW_EN
    chk("pass_no_ovf", overflow, 0);
`endif
    for (int i = 1; i < 16; i++) begin
      chk("pass_drain", out_data, 8'(8'h20 + i));
      step();
    end
    chk("pass_tail", out_data, 8'h99);
    step();
    chk("pass_empty", out_data_available, 0);
    receiver_ready = 1'b0;

    // Streaming with pointer wrap, occupancy held at one
    do_reset();
    receiver_ready = 1'b1;
    in_data_available = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(i);
      step();
      chk("stream_data", out_data, 8'(i));
      chk("stream_avail", out_data_available, 1);
      chk("stream_ready", in_data_ready, 1);
    end
    in_data_available = 1'b0;
    step();
    chk("stream_empty", out_data_available, 0);
    receiver_ready = 1'b0;

    // Async reset mid-cycle discards queued words
    in_data_available = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hA0 + i);
      step();
    end
    in_data_available = 1'b0;
    chk("pre_arst_avail", out_data_available, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_avail", out_data_available, 0);
    chk("arst_ready", in_data_ready, 0);
    chk("arst_data", out_data, 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_arst_avail", out_data_available, 0);
    chk("post_arst_ready", in_data_ready, 1);
    step();
    chk("post_arst_idle", out_data_available, 0);
    in_data = 8'h55;
    in_data_available = 1'b1;
    step();
    in_data_available = 1'b0;
    chk("post_arst_head", out_data, 8'h55);
    receiver_ready = 1'b1;
    step();
    chk("post_arst_empty", out_data_available, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Elastic buffer directly downstream of the two-channel stream muxer.
- Absorbs the muxer's one-word-per-cycle strobes and feeds the terminal's character consumer through a standard valid/ready output.
- Its input-side ready signal drives the muxer's receiver_ready.
- Ready carries one cycle of slack: the muxer emits a word one cycle after it sees ready, so the FIFO reserves one slot for that in-flight word.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 words).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  word from the muxer.
- in_data_available  input  1  write strobe; one word per high cycle, not gated by ready.
- in_data_ready  output  1  space advisory to the muxer (its receiver_ready).
- out_data  output  DATA_WIDTH  head-of-queue word.
- out_data_available  output  1  queue non-empty.
- receiver_ready  input  1  downstream consumer accepts the head word this cycle.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH.
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = count = 0.
  - out_data_available = 0, in_data_ready = 0, out_data = 0.
  - Array contents are not cleared.
- Write: on each edge with in_data_available=1 and count<DEPTH, mem[wr_ptr] <= in_data and wr_ptr++.
- Read: on each edge with out_data_available=1 and receiver_ready=1, rd_ptr++.
  - receiver_ready while empty has no effect.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous read and write, including at count=DEPTH, where the write is accepted because the read frees a slot the same edge.
- in_data_ready = (count < DEPTH-1), combinational from registered count only.
  - Guarantees no overflow if upstream only strobes in the cycle after it saw ready high.
  - Example: ready high at count=DEPTH-2 plus a strobe that cycle -> count=DEPTH-1, ready low; the in-flight strobe then lands at count=DEPTH.
  - in_data_ready is forced 0 while reset is asserted.
- Output is first-word-fall-through:
  - out_data_available = (count != 0).
  - out_data = mem[rd_ptr] when available, else all-zero.
  - Latency: a word written at edge t is visible on out_data and out_data_available immediately after edge t (one cycle, input to output).
  - No combinational bypass when empty.
- Overflow: in_data_available=1 at count=DEPTH with no simultaneous read drops the word. Pointers and count are unchanged.
- Ordering is strict FIFO; pointer wrap from DEPTH-1 to 0 is seamless.
- Reset mid-operation: queued words are discarded; outputs return to reset values asynchronously.

Optional Feature:
- Macro: STREAM_FIFO_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - Set to 1 on any edge where a word is dropped per the overflow rule.
  - Sticky until reset.
- Undefined:
  - No overflow port, no associated logic.
  - Drop behaviour is identical.

Test Plan:
- Reset then idle -> out_data_available=0, out_data=0, in_data_ready=1 from the first cycle after release; count stays 0.
- Strobe 0x41, 0x42, 0x43 on three consecutive cycles with receiver_ready=0 -> out_data=0x41 one cycle after the first strobe. Then raise receiver_ready -> 0x41, 0x42, 0x43 in order, then out_data_available=0.
- Fill with 15 writes (0x00..0x0E), receiver_ready=0 -> in_data_ready drops when count reaches 15. A 16th strobe (0x0F) is accepted, count=16. A 17th strobe (0xFF) is dropped; with STREAM_FIFO_OVERFLOW_EN, overflow=1. Drain -> exactly 0x00..0x0F.
- At count=16, strobe 0x99 while receiver_ready=1 -> head consumed, 0x99 stored, count stays 16, no overflow.
- Continuous write+read for 40 cycles (pointer wrap twice), data = cycle index -> output sequence is identical and gap-free after one cycle of latency; count stays 1.
- Load 5 words, assert reset asynchronously mid-cycle -> out_data_available and in_data_ready fall without waiting for a clock edge. After release the FIFO is empty and old words never reappear.
